// File: rtl/mux_pkg.sv
// mux_pkg: constants and types shared by the 16:1 mux and its downstream stages.
//   WIDTH             data width of the mux output
//   DEPTH             number of mux channels
//   SELECT_LINE_DEPTH select lines needed to address DEPTH channels
//   chan_t            channel index type
//   cap_entry_t       tagged capture word {chan, data} stored by mux_capture_fifo
package mux_pkg;

  localparam int WIDTH             = 32;
  localparam int DEPTH             = 16;
  localparam int SELECT_LINE_DEPTH = $clog2(DEPTH);

  typedef logic [SELECT_LINE_DEPTH-1:0] chan_t;

  typedef struct packed {
    chan_t              chan;
    logic [WIDTH-1:0]   data;
  } cap_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO for an arbitrary element type.
//   clk, rst  clock and synchronous active-high reset (empties the FIFO)
//   push      write din this cycle; accepted when not full, or when full and a pop happens
//   pop       remove the head entry; ignored when empty
//   din       entry to write
//   head      current head entry (combinational), zero while empty
//   full      fill == DEPTH
//   empty     fill == 0
//   fill      occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap without extra logic.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    fill_reg;
  logic           wr_en;
  logic           rd_en;

  assign empty = (fill_reg == '0);
  assign full  = (fill_reg == (AW+1)'(DEPTH));
  assign fill  = fill_reg;

  // A pop frees the slot the write lands in, so a full FIFO still accepts a push alongside a pop.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Storage carries no reset; the empty gating on head hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr_reg];
    end
  end

  a_fill_bound: assert property (@(posedge clk) disable iff (rst) fill_reg <= (AW+1)'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: rtl/mux_capture_fifo.sv
// mux_capture_fifo: tags each mux result with its channel index and buffers it for the next stage.
//   clk, rst    clock and synchronous active-high reset
//   sel_valid   a select was driven to the mux this cycle
//   s           select bits as driven to the mux, s[0] is the index MSB
//   cout        mux output, valid the cycle after sel_valid
//   out_valid   head entry available
//   out_ready   consumer accepts the head entry
//   out_data    head data
//   out_chan    head channel index
//   fill        FIFO occupancy
//   overflow    sticky flag, a tagged word was dropped because the FIFO was full
//   drop_cnt    saturating count of dropped words
//   clr_ovf     clears overflow and drop_cnt (wins over a same-cycle drop)
module mux_capture_fifo #(
  parameter int WIDTH             = mux_pkg::WIDTH,
  parameter int DEPTH             = mux_pkg::DEPTH,
  parameter int SELECT_LINE_DEPTH = mux_pkg::SELECT_LINE_DEPTH,
  parameter int FIFO_DEPTH        = 8,
  parameter int CNT_W             = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel_valid,
  input  logic                          s [SELECT_LINE_DEPTH],
  input  logic [WIDTH-1:0]              cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [SELECT_LINE_DEPTH-1:0]  out_chan,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt,
  input  logic                          clr_ovf
);

  import mux_pkg::*;

  logic [SELECT_LINE_DEPTH-1:0] chan_next;
  logic [SELECT_LINE_DEPTH-1:0] chan_d_reg;
  logic                         v_d_reg;
  cap_entry_t                   entry_in;
  cap_entry_t                   head;
  logic                         full;
  logic                         empty;
  logic                         pop;
  logic                         drop;
  logic                         overflow_reg;
  logic [CNT_W-1:0]             drop_cnt_reg;

  // The mux sees s[0] as its most significant select line, so the index is s reversed.
  for (genvar gi = 0; gi < SELECT_LINE_DEPTH; gi++) begin : g_chan
    assign chan_next[SELECT_LINE_DEPTH-1-gi] = s[gi];
  end

  // The mux registers its output, so delay valid and channel by one cycle to meet cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_d_reg    <= 1'b0;
      chan_d_reg <= '0;
    end else begin
      v_d_reg    <= sel_valid;
      chan_d_reg <= chan_next;
    end
  end

  always_comb begin
    entry_in      = '0;
    entry_in.chan = chan_d_reg;
    entry_in.data = cout;
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .T     (cap_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v_d_reg),
    .pop   (pop),
    .din   (entry_in),
    .head  (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign out_data = head.data;
  assign out_chan = head.chan;

  // The FIFO refuses a push only when full with no pop; that word is lost.
  assign drop = v_d_reg && full && !pop;

  always_ff @(posedge clk) begin
    if (rst || clr_ovf) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

  a_chan_range: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (int'(out_chan) < DEPTH));
  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_chan)));

endmodule

// File: tb/tb_mux_capture_fifo.sv
// tb_mux_capture_fifo: directed scenarios for mux_capture_fifo; the bench plays the role of
// the registered mux, presenting cout the cycle after each sel_valid.
module tb_mux_capture_fifo;

  localparam int W  = 32;
  localparam int SW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel_valid;
  logic          s [SW];
  logic [W-1:0]  cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic [3:0]    fill;
  logic          overflow;
  logic [CW-1:0] drop_cnt;
  logic          clr_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_capture_fifo #(
    .WIDTH             (W),
    .DEPTH             (16),
    .SELECT_LINE_DEPTH (SW),
    .FIFO_DEPTH        (8),
    .CNT_W             (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .fill      (fill),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [3:0] ch);
    s[0] = ch[3];
    s[1] = ch[2];
    s[2] = ch[1];
    s[3] = ch[0];
  endtask

  // n selects on consecutive cycles; cout for select k follows one cycle later as base_data+k.
  task automatic push_words(input int n, input int base_chan, input logic [W-1:0] base_data);
    for (int cyc = 0; cyc <= n; cyc++) begin
      sel_valid = (cyc < n);
      set_sel(4'(base_chan + cyc));
      cout = (cyc > 0) ? base_data + W'(cyc - 1) : '0;
      step();
    end
    sel_valid = 1'b0;
    cout      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (fill !== 4'd0) begin n_bad++; $display("FAIL rst_fill: got %0d want 0", fill); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_chan !== 4'd0) begin n_bad++; $display("FAIL rst_out_chan: got %0d want 0", out_chan); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_latency_tag();
    out_ready = 1'b0;
    sel_valid = 1'b1;
    s[0] = 1'b1; s[1] = 1'b0; s[2] = 1'b1; s[3] = 1'b1;
    step();
    sel_valid = 1'b0;
    cout      = 32'hDEAD_BEEF;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_no_bypass: got %b want 0", out_valid); end
    step();
    cout = '0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_chan !== 4'd11) begin n_bad++; $display("FAIL lat_out_chan: got %0d want 11", out_chan); end
    n_cmp++; if (out_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lat_out_data: got %h want deadbeef", out_data); end
    n_cmp++; if (fill !== 4'd1) begin n_bad++; $display("FAIL lat_fill: got %0d want 1", fill); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (fill !== 4'd0) begin n_bad++; $display("FAIL lat_fill_after_pop: got %0d want 0", fill); end
  endtask

  task automatic test_order();
    int k;
    logic [W-1:0] exp_d;
    k = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (out_valid) begin
        exp_d = W'(k * 3);
        n_cmp++;
        if (out_chan !== 4'(k) || out_data !== exp_d) begin
          n_bad++;
          $display("FAIL order_word%0d: got chan %0d data %0d want chan %0d data %0d", k, out_chan, out_data, k, exp_d);
        end
        k++;
      end
      sel_valid = (cyc < 8);
      set_sel(4'(cyc));
      cout = (cyc > 0) ? W'((cyc - 1) * 3) : '0;
      step();
    end
    sel_valid = 1'b0;
    cout      = '0;
    out_ready = 1'b0;
    n_cmp++; if (k !== 8) begin n_bad++; $display("FAIL order_count: got %0d want 8", k); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_d;
    out_ready = 1'b0;
    push_words(10, 0, 32'h100);
    n_cmp++; if (fill !== 4'd8) begin n_bad++; $display("FAIL ovf_fill: got %0d want 8", fill); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
    n_cmp++; if (out_data !== 32'h100) begin n_bad++; $display("FAIL ovf_head_held: got %h want 100", out_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_d = 32'h100 + W'(k);
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 4'(k) || out_data !== exp_d) begin
        n_bad++;
        $display("FAIL ovf_drain%0d: got v %b chan %0d data %h want v 1 chan %0d data %h", k, out_valid, out_chan, out_data, k, exp_d);
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (fill !== 4'd0) begin n_bad++; $display("FAIL ovf_drained_fill: got %0d want 0", fill); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL ovf_clr_cnt: got %0d want 0", drop_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_flag: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] exp_d;
    out_ready = 1'b0;
    push_words(8, 0, 32'h200);
    n_cmp++; if (fill !== 4'd8) begin n_bad++; $display("FAIL fpp_fill_pre: got %0d want 8", fill); end
    sel_valid = 1'b1;
    set_sel(4'd8);
    step();
    sel_valid = 1'b0;
    cout      = 32'h208;
    out_ready = 1'b1;
    n_cmp++; if (out_data !== 32'h200) begin n_bad++; $display("FAIL fpp_head_pre: got %h want 200", out_data); end
    step();
    cout      = '0;
    out_ready = 1'b0;
    n_cmp++; if (fill !== 4'd8) begin n_bad++; $display("FAIL fpp_fill_post: got %0d want 8", fill); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL fpp_drop_cnt: got %0d want 0", drop_cnt); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_d = 32'h201 + W'(k);
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 4'(k + 1) || out_data !== exp_d) begin
        n_bad++;
        $display("FAIL fpp_drain%0d: got v %b chan %0d data %h want v 1 chan %0d data %h", k, out_valid, out_chan, out_data, k + 1, exp_d);
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push_words(5, 0, 32'h300);
    n_cmp++; if (fill !== 4'd5) begin n_bad++; $display("FAIL rmid_fill_pre: got %0d want 5", fill); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (fill !== 4'd0) begin n_bad++; $display("FAIL rmid_fill: got %0d want 0", fill); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    push_words(1, 5, 32'hCAFE_F00D);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_push_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_chan !== 4'd5) begin n_bad++; $display("FAIL rmid_push_chan: got %0d want 5", out_chan); end
    n_cmp++; if (out_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rmid_push_data: got %h want cafef00d", out_data); end
    n_cmp++; if (fill !== 4'd1) begin n_bad++; $display("FAIL rmid_push_fill: got %0d want 1", fill); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (fill !== 4'd0) begin n_bad++; $display("FAIL rmid_final_fill: got %0d want 0", fill); end
  endtask

  initial begin
    rst       = 1'b1;
    sel_valid = 1'b0;
    cout      = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    set_sel(4'd0);
    test_reset();
    test_latency_tag();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
